n4v_bus_sram_slave: RTL and testbench
=====================================

Name: n4v_bus_sram_slave

Overview:
- 16-bit bus responder (target side) for the N4V bus that the address-translation master drives during page-table walks and translated data cycles.
- Holds page-directory/page-table words and general data in an on-chip word array.
- Answers cyc/stb cycles with a level ack that is held until stb drops, which is the handshake the walking master expects (it waits for ~ack before raising stb again).
- Configurable wait states, base-address decode, byte-lane writes.

Parameters:
BASE, 32'h1FFF0000, byte base address of the window; bits below SIZE_LOG2 ignored
SIZE_LOG2, 12, window size in bytes = 2**SIZE_LOG2; array depth = 2**(SIZE_LOG2-1) words
WAIT_STATES, 1, extra cycles inserted before ack (0..15)

Ports:
clk_i  in  1  bus clock
rst_ni  in  1  asynchronous active-low reset
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe
we_i  in  1  write enable
sel_i  in  2  byte lane selects ([1]=dat[15:8], [0]=dat[7:0])
adr_i  in  32  byte address; adr_i[0] ignored
dat_i  in  16  write data
ack_o  out  1  acknowledge, level, held while stb_i high
dat_o  out  16  read data, valid while ack_o=1 on a read
hit_o  out  1  combinational: cyc_i & stb_i & adr_i[31:SIZE_LOG2]==BASE[31:SIZE_LOG2]

Behaviour:
- Reset (rst_ni=0, async): state=IDLE, ack_o=0, dat_o=0, wait counter=0, latched address/we/sel/data cleared. Array contents not reset. Reset during WAIT cancels a pending write (no array update).
- States: IDLE, WAIT, ACK.
- IDLE: on hit_o=1 latch word address adr_i[SIZE_LOG2-1:1], we_i, sel_i, dat_i; load counter=WAIT_STATES; go WAIT.
- WAIT: if cyc_i=0 or stb_i=0 -> IDLE, no access (abort). Else if counter==0 -> perform access, ack_o<=1, go ACK. Else counter decrements.
- Access at the WAIT->ACK edge: write updates only lanes with sel=1; sel=2'b00 write acks but changes nothing. Read loads dat_o from array at latched address.
- Latency: ack_o rises WAIT_STATES+2 edges after the first edge sampling hit_o=1 (WAIT_STATES=0 -> 2 edges).
- ACK: ack_o stays 1 while stb_i=1 (cyc_i alone does not release). When stb_i=0 sampled -> ack_o<=0, dat_o held, go IDLE. Earliest next acceptance: the edge after returning to IDLE, so ack_o is always low for at least one cycle between transfers.
- Inputs changing during WAIT/ACK (address, data, we, sel) are ignored; latched values govern.
- Non-hit cycles: no state change, ack_o stays 0 (other slaves respond).
- Read-after-write to the same word in consecutive transfers returns the new data.
- Address wrap: word index is latched bits only; no carry beyond the window.

Test Plan:
- Reset: rst_ni low mid-ACK -> ack_o=0, dat_o=0 immediately (async); after release, state is IDLE and no spurious ack.
- WAIT_STATES=1, write adr=32'h1FFF0010 dat=16'hA5C3 sel=2'b11, then read same -> ack_o rises 3 edges after stb sampled; read dat_o=16'hA5C3.
- Byte lanes: word 16'h1234 at 32'h1FFF0020, write sel=2'b10 dat=16'hFF00 -> read returns 16'hFF34; sel=2'b00 write -> acked, data unchanged.
- Handshake hold: master keeps stb_i=1 for 5 cycles after ack -> ack_o stays 1 for all 5; stb_i drops -> ack_o=0 next edge; master re-asserts stb immediately -> new ack only after idle gap.
- Abort: stb_i dropped during WAIT on a write of 16'hDEAD to 32'h1FFF0004 -> no ack, later read returns old value.
- Decode: cycle to 32'h1FFE0004 or 32'h20000004 -> hit_o=0, ack_o never asserts; page-table style pair reads at 32'h1FFF0FFC/0FFE return both stored halves in order.

Source files
------------

// File: rtl/n4v_bus_sram_slave.sv
// N4V bus SRAM target: word-array responder with base-address decode,
// programmable wait states, byte-lane writes and a level ack that is held
// until the master drops stb.
module n4v_bus_sram_slave #(
  parameter logic [31:0] BASE        = 32'h1FFF0000,
  parameter int          SIZE_LOG2   = 12,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [15:0] dat_i,
  output logic        ack_o,
  output logic [15:0] dat_o,
  output logic        hit_o
);

  localparam int AW    = SIZE_LOG2 - 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [AW-1:0] r_adr;
  logic          r_we;
  logic [1:0]    r_sel;
  logic [15:0]   r_dat;
  logic [3:0]    r_cnt;
  logic          r_ack;
  logic [15:0]   r_datO;
  logic [15:0]   r_mem [DEPTH];

  logic          w_bus;
  logic          w_hit;
  logic          w_latch;
  logic          w_access;
  logic          w_ackClr;
  logic          w_unusedAdr0;

  // Byte address bit 0 carries no information for a 16-bit word array.
  assign w_unusedAdr0 = adr_i[0];

  assign w_bus = cyc_i & stb_i;
  assign w_hit = w_bus & (adr_i[31:SIZE_LOG2] == BASE[31:SIZE_LOG2]);

  assign hit_o = w_hit;
  assign ack_o = r_ack;
  assign dat_o = r_datO;

  // Next-state decode: accept in IDLE, count down or abort in WAIT,
  // hold ack in ACK until the master drops stb.
  always_comb begin
    w_nextState = r_state;
    w_latch     = 1'b0;
    w_access    = 1'b0;
    w_ackClr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_latch     = 1'b1;
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_bus) begin
          w_nextState = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_nextState = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!stb_i) begin
          w_ackClr    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register; an async reset during WAIT drops the pending access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request latch, wait counter, ack level and read-data register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_adr  <= '0;
      r_we   <= 1'b0;
      r_sel  <= 2'b00;
      r_dat  <= 16'h0000;
      r_cnt  <= 4'd0;
      r_ack  <= 1'b0;
      r_datO <= 16'h0000;
    end else begin
      if (w_latch) begin
        r_adr <= adr_i[SIZE_LOG2-1:1];
        r_we  <= we_i;
        r_sel <= sel_i;
        r_dat <= dat_i;
        r_cnt <= 4'(WAIT_STATES);
      end else if ((r_state == ST_WAIT) && w_bus && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_ack <= 1'b1;
        if (!r_we) begin
          r_datO <= r_mem[r_adr];
        end
      end else if (w_ackClr) begin
        r_ack <= 1'b0;
      end
    end
  end

  // Word array, not reset; writes touch only the selected byte lanes.
  always_ff @(posedge clk_i) begin
    if (w_access && r_we) begin
      if (r_sel[0]) begin
        r_mem[r_adr][7:0] <= r_dat[7:0];
      end
      if (r_sel[1]) begin
        r_mem[r_adr][15:8] <= r_dat[15:8];
      end
    end
  end

endmodule

// File: tb/tb_n4v_bus_sram_slave.sv
// Self-checking bench for n4v_bus_sram_slave: directed scenarios plus
// randomized transfers checked against a word-indexed memory model.
module tb_n4v_bus_sram_slave;

  localparam int WS      = 1;
  localparam int EXP_LAT = WS + 2;

  logic        clk_i;
  logic        rst_ni;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [1:0]  sel_i;
  logic [31:0] adr_i;
  logic [15:0] dat_i;
  logic        ack_o;
  logic [15:0] dat_o;
  logic        hit_o;

  int checks;
  int errors;

  // Reference memory: word index -> 16-bit contents
  logic [15:0] model [int];

  n4v_bus_sram_slave #(
    .BASE(32'h1FFF0000),
    .SIZE_LOG2(12),
    .WAIT_STATES(WS)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .cyc_i(cyc_i),
    .stb_i(stb_i),
    .we_i(we_i),
    .sel_i(sel_i),
    .adr_i(adr_i),
    .dat_i(dat_i),
    .ack_o(ack_o),
    .dat_o(dat_o),
    .hit_o(hit_o)
  );

  // Free-running bus clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a & 32'h0000_0FFF) >> 1);
  endfunction

  function automatic logic [15:0] modelRead(input logic [31:0] a);
    if (model.exists(wordIdx(a))) return model[wordIdx(a)];
    return 16'h0000;
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [1:0] s, input logic [15:0] d);
    logic [15:0] v;
    v = modelRead(a);
    if (s[0]) v[7:0] = d[7:0];
    if (s[1]) v[15:8] = d[15:8];
    model[wordIdx(a)] = v;
  endtask

  // Start a transfer and wait (bounded) for ack; returns edges-to-ack and read data.
  // Inputs are scrambled after the accepting edge since the target must use latched values.
  task automatic busXfer(input logic immediate, input logic [31:0] a, input logic w,
                         input logic [1:0] s, input logic [15:0] d,
                         output logic [15:0] rd, output int lat);
    if (!immediate) @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; sel_i = s; adr_i = a; dat_i = d;
    lat = -1;
    rd  = 16'h0000;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i); #1;
      if (n == 1) begin
        adr_i = $urandom; dat_i = 16'($urandom); we_i = 1'($urandom); sel_i = 2'($urandom);
      end
      if (ack_o) begin
        lat = n;
        rd  = dat_o;
        break;
      end
    end
  endtask

  // Drop the strobe and report ack one edge later.
  task automatic busRelease(output logic ackAfter);
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
    ackAfter = ack_o;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    int lat;
    logic a;
    int sawAck;
    rst_ni = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    sel_i = 2'b00; adr_i = 32'h0; dat_i = 16'h0;
    #1;
    checks++; if (ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", ack_o); end
    checks++; if (dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dat got %h want 0000", dat_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    busXfer(1'b0, 32'h1FFF0100, 1'b1, 2'b11, 16'h5A5A, rd, lat);
    modelWrite(32'h1FFF0100, 2'b11, 16'h5A5A);
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0100, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("[TB] FAIL reset_preread got %h want 5a5a", rd); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_async_ack got %b want 0", ack_o); end
    checks++; if (dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_async_dat got %h want 0000", dat_o); end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    sawAck = 0;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (ack_o) sawAck++;
    end
    checks++; if (sawAck !== 0) begin errors++; $display("[TB] FAIL reset_spurious_ack got %0d acks want 0", sawAck); end

    // Reset while a write is waiting must not update the array
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 2'b11;
    adr_i = 32'h1FFF0100; dat_i = 16'h0BAD;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    busXfer(1'b0, 32'h1FFF0100, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (rd !== modelRead(32'h1FFF0100)) begin errors++; $display("[TB] FAIL reset_cancel_write got %h want %h", rd, modelRead(32'h1FFF0100)); end
    busRelease(a);
  endtask

  task automatic test_basic();
    logic [15:0] rd;
    int lat;
    logic a;
    busXfer(1'b0, 32'h1FFF0010, 1'b1, 2'b11, 16'hA5C3, rd, lat);
    modelWrite(32'h1FFF0010, 2'b11, 16'hA5C3);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL basic_wr_latency got %0d want %0d", lat, EXP_LAT); end
    busRelease(a);
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL basic_wr_release got %b want 0", a); end
    busXfer(1'b0, 32'h1FFF0010, 1'b0, 2'b00, 16'h0000, rd, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL basic_rd_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (rd !== 16'hA5C3) begin errors++; $display("[TB] FAIL basic_rd_data got %h want a5c3", rd); end
    busRelease(a);
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rd;
    int lat;
    logic a;
    busXfer(1'b0, 32'h1FFF0020, 1'b1, 2'b11, 16'h1234, rd, lat);
    modelWrite(32'h1FFF0020, 2'b11, 16'h1234);
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0020, 1'b1, 2'b10, 16'hFF00, rd, lat);
    modelWrite(32'h1FFF0020, 2'b10, 16'hFF00);
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0020, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (rd !== modelRead(32'h1FFF0020)) begin errors++; $display("[TB] FAIL lanes_upper got %h want %h", rd, modelRead(32'h1FFF0020)); end
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0020, 1'b1, 2'b00, 16'hBEEF, rd, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL lanes_none_ack got %0d want %0d", lat, EXP_LAT); end
    modelWrite(32'h1FFF0020, 2'b00, 16'hBEEF);
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0020, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (rd !== modelRead(32'h1FFF0020)) begin errors++; $display("[TB] FAIL lanes_none_data got %h want %h", rd, modelRead(32'h1FFF0020)); end
    busRelease(a);
  endtask

  task automatic test_handshake();
    logic [15:0] rd;
    logic [15:0] d;
    int lat;
    logic a;
    int drops;
    d = 16'($urandom);
    busXfer(1'b0, 32'h1FFF0030, 1'b1, 2'b11, d, rd, lat);
    modelWrite(32'h1FFF0030, 2'b11, d);
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0030, 1'b0, 2'b11, 16'h0000, rd, lat);
    drops = 0;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (ack_o !== 1'b1 || dat_o !== d) drops++;
    end
    checks++; if (drops !== 0) begin errors++; $display("[TB] FAIL hold_ack_5 got %0d bad cycles want 0", drops); end
    busRelease(a);
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL hold_release got %b want 0", a); end
    checks++; if (dat_o !== d) begin errors++; $display("[TB] FAIL hold_dat_kept got %h want %h", dat_o, d); end
    busXfer(1'b1, 32'h1FFF0030, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL hold_regap_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (rd !== d) begin errors++; $display("[TB] FAIL hold_regap_data got %h want %h", rd, d); end
    busRelease(a);
  endtask

  task automatic test_abort();
    logic [15:0] rd;
    int lat;
    logic a;
    int sawAck;
    busXfer(1'b0, 32'h1FFF0004, 1'b1, 2'b11, 16'h7777, rd, lat);
    modelWrite(32'h1FFF0004, 2'b11, 16'h7777);
    busRelease(a);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 2'b11;
    adr_i = 32'h1FFF0004; dat_i = 16'hDEAD;
    @(posedge clk_i); #1;
    sawAck = ack_o ? 1 : 0;
    @(negedge clk_i);
    stb_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (ack_o) sawAck++;
    end
    cyc_i = 1'b0; we_i = 1'b0;
    checks++; if (sawAck !== 0) begin errors++; $display("[TB] FAIL abort_no_ack got %0d acks want 0", sawAck); end
    busXfer(1'b0, 32'h1FFF0004, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (rd !== modelRead(32'h1FFF0004)) begin errors++; $display("[TB] FAIL abort_old_data got %h want %h", rd, modelRead(32'h1FFF0004)); end
    busRelease(a);
  endtask

  task automatic test_decode();
    logic [31:0] missAddr [2];
    logic [15:0] rd;
    logic [15:0] d0;
    logic [15:0] d1;
    int lat;
    logic a;
    int sawAck;
    missAddr[0] = 32'h1FFE0004;
    missAddr[1] = 32'h20000004;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 2'b11; adr_i = missAddr[i];
      #1;
      checks++; if (hit_o !== 1'b0) begin errors++; $display("[TB] FAIL decode_miss_hit%0d got %b want 0", i, hit_o); end
      sawAck = 0;
      repeat (6) begin
        @(posedge clk_i); #1;
        if (ack_o) sawAck++;
      end
      checks++; if (sawAck !== 0) begin errors++; $display("[TB] FAIL decode_miss_ack%0d got %0d acks want 0", i, sawAck); end
      cyc_i = 1'b0; stb_i = 1'b0;
    end
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 32'h1FFF0FFC;
    #1;
    checks++; if (hit_o !== 1'b1) begin errors++; $display("[TB] FAIL decode_hit got %b want 1", hit_o); end
    cyc_i = 1'b0; stb_i = 1'b0;
    d0 = 16'($urandom);
    d1 = 16'($urandom);
    busXfer(1'b0, 32'h1FFF0FFC, 1'b1, 2'b11, d0, rd, lat);
    modelWrite(32'h1FFF0FFC, 2'b11, d0);
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0FFE, 1'b1, 2'b11, d1, rd, lat);
    modelWrite(32'h1FFF0FFE, 2'b11, d1);
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0FFC, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (rd !== d0) begin errors++; $display("[TB] FAIL pair_lo got %h want %h", rd, d0); end
    busRelease(a);
    busXfer(1'b0, 32'h1FFF0FFE, 1'b0, 2'b11, 16'h0000, rd, lat);
    checks++; if (rd !== d1) begin errors++; $display("[TB] FAIL pair_hi got %h want %h", rd, d1); end
    busRelease(a);
  endtask

  task automatic test_random();
    logic [31:0] addrs [8];
    logic [31:0] a32;
    logic [19:0] upper;
    logic [15:0] rd;
    logic [15:0] d;
    logic [1:0]  s;
    logic        w;
    int lat;
    logic a;
    int k;
    int sawAck;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'h1FFF0000 | (32'($urandom_range(0, 2047)) << 1) | 32'($urandom_range(0, 1));
      d = 16'($urandom);
      busXfer(1'b0, addrs[i], 1'b1, 2'b11, d, rd, lat);
      modelWrite(addrs[i], 2'b11, d);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL rnd_init_latency got %0d want %0d", lat, EXP_LAT); end
      busRelease(a);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        upper = 20'($urandom);
        if (upper == 20'h1FFF0) upper = 20'h1FFF1;
        a32 = {upper, 12'($urandom)};
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'($urandom); sel_i = 2'b11; adr_i = a32;
        #1;
        sawAck = hit_o ? 1 : 0;
        repeat (3) begin
          @(posedge clk_i); #1;
          if (ack_o) sawAck++;
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        checks++; if (sawAck !== 0) begin errors++; $display("[TB] FAIL rnd_miss %h got %0d hits/acks want 0", a32, sawAck); end
      end else begin
        k = $urandom_range(0, 7);
        w = 1'($urandom);
        s = 2'($urandom);
        d = 16'($urandom);
        busXfer(1'b0, addrs[k], w, s, d, rd, lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL rnd_latency op%0d got %0d want %0d", i, lat, EXP_LAT); end
        if (w) begin
          modelWrite(addrs[k], s, d);
        end else begin
          checks++; if (rd !== modelRead(addrs[k])) begin errors++; $display("[TB] FAIL rnd_read op%0d adr %h got %h want %h", i, addrs[k], rd, modelRead(addrs[k])); end
        end
        busRelease(a);
        checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL rnd_release op%0d got %b want 0", i, a); end
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_handshake();
    test_abort();
    test_decode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
